// File: rtl/img_pkg.sv
// Shared image geometry and copy-engine state encoding, also used by
// memory_control and the top level.
package img_pkg;

  localparam int IMG_W  = 320;
  localparam int IMG_H  = 240;
  localparam int PIXELS = IMG_W * IMG_H;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } copy_state_t;

endpackage

// File: rtl/frame_copy_engine_if.sv
// Control and RAM-side bundle of frame_copy_engine; fill_en/fill_color exist
// only when COPY_FILL_EN is defined.
interface frame_copy_engine_if #(
  parameter int ADDR_W = img_pkg::ADDR_W,
  parameter int DATA_W = img_pkg::DATA_W
);

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] src_q;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;

`ifdef COPY_FILL_EN
  logic              fill_en;
  logic [DATA_W-1:0] fill_color;

  modport master (
    output start, abort, src_q, fill_en, fill_color,
    input  busy, done, rd_addr, wr_addr, wr_data, wr_en
  );

  modport slave (
    input  start, abort, src_q, fill_en, fill_color,
    output busy, done, rd_addr, wr_addr, wr_data, wr_en
  );
`else
  modport master (
    output start, abort, src_q,
    input  busy, done, rd_addr, wr_addr, wr_data, wr_en
  );

  modport slave (
    input  start, abort, src_q,
    output busy, done, rd_addr, wr_addr, wr_data, wr_en
  );
`endif

endinterface

// File: rtl/copy_delay_line.sv
// {valid, addr} shift register matching the source RAM read latency, so each
// write address lines up with the read data it belongs to.
module copy_delay_line #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [ADDR_W-1:0] in_addr_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  output logic [ADDR_W-1:0] out_addr_o
);

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] addr_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      // flush also kills the read being issued in the flush cycle
      valid_q[0] <= in_valid_i & ~flush_i;
      addr_q[0]  <= in_addr_i;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1] & ~flush_i;
        addr_q[i]  <= addr_q[i-1];
      end
    end
  end

  assign out_valid_o = valid_q[DEPTH-1];
  assign out_addr_o  = addr_q[DEPTH-1];

endmodule

// File: rtl/frame_copy_engine.sv
// Pipelined working-RAM to display-RAM frame copy, one pixel per cycle.
// Defining COPY_FILL_EN adds a solid-colour fill mode (no reads issued).
module frame_copy_engine #(
  parameter int ADDR_W = img_pkg::ADDR_W,
  parameter int DATA_W = img_pkg::DATA_W,
  parameter int PIXELS = img_pkg::PIXELS,
  parameter int RD_LAT = img_pkg::RD_LAT
) (
  input logic                clock_i,
  input logic                reset_i,
  frame_copy_engine_if.slave bus
);
  import img_pkg::*;

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one read (or fill write) per cycle, counter 0..PIXELS-1
  // DRAIN | no reads, waiting for the delay line to empty
  // DONE  | one-cycle done pulse

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(PIXELS - 1);
  localparam logic [1:0]        DRAIN_INIT = 2'(RD_LAT - 1);

  copy_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        drain_q, drain_d;
  logic              flush;
  logic              fill_mode;
  logic              dl_valid;
  logic [ADDR_W-1:0] dl_addr;

`ifdef COPY_FILL_EN
  logic              fill_q, fill_d;
  logic [DATA_W-1:0] color_q, color_d;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fill_q  <= 1'b0;
      color_q <= '0;
    end else begin
      fill_q  <= fill_d;
      color_q <= color_d;
    end
  end

  assign fill_mode = fill_q;
`else
  assign fill_mode = 1'b0;
`endif

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    flush   = 1'b0;
`ifdef COPY_FILL_EN
    fill_d  = fill_q;
    color_d = color_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          cnt_d   = '0;
`ifdef COPY_FILL_EN
          fill_d  = bus.fill_en;
          color_d = bus.fill_color;
`endif
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (cnt_q == LAST_ADDR) begin
          // fill writes directly, so there is nothing in flight to drain
          state_d = fill_mode ? DONE : DRAIN;
          drain_d = DRAIN_INIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          state_d = IDLE;
          flush   = 1'b1;
        end else if (drain_q == '0) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  copy_delay_line #(
    .DEPTH  (RD_LAT),
    .ADDR_W (ADDR_W)
  ) u_delay (
    .clk_i       (clock_i),
    .rst_i       (reset_i),
    .in_valid_i  ((state_q == RUN) && !fill_mode),
    .in_addr_i   (cnt_q),
    .flush_i     (flush),
    .out_valid_o (dl_valid),
    .out_addr_o  (dl_addr)
  );

  assign bus.busy    = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done    = (state_q == DONE);
  assign bus.rd_addr = fill_mode ? '0 : cnt_q;
  assign bus.wr_en   = fill_mode ? (state_q == RUN) : dl_valid;
  assign bus.wr_addr = fill_mode ? cnt_q : dl_addr;
`ifdef COPY_FILL_EN
  assign bus.wr_data = fill_mode ? color_q : bus.src_q;
`else
  assign bus.wr_data = bus.src_q;
`endif

endmodule

// File: tb/tb_frame_copy_engine.sv
// Scoreboard bench for frame_copy_engine (small frame) with a latency-accurate
// source RAM model; fill-mode cases are built only when COPY_FILL_EN is defined.
module tb_frame_copy_engine;

  localparam int P  = 8;
  localparam int L  = 2;
  localparam int AW = 17;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  frame_copy_engine_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  frame_copy_engine #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .PIXELS (P),
    .RD_LAT (L)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus)
  );

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  busy_lo = 1;
  int  busy_hi = 0;
  int  idle_from = 0;
  int  done_rd = 0;
  bit  mon_en = 1'b0;

`ifdef COPY_FILL_EN
  bit        fill_req = 1'b0;
  logic [7:0] fill_col = 8'h00;
`endif

  // source RAM: data for the address presented L cycles earlier
  logic [7:0]    mem  [P];
  logic [AW-1:0] pipe [L];

  always @(posedge clk) begin
    pipe[0] <= bus.rd_addr;
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.src_q = mem[int'(pipe[L-1]) % P];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", n, cyc, got, exp);
    end
  endtask

  // drop everything the model expected after cycle c
  function automatic void cut(input int c);
    while (wq.size() > 0 && wq[$].cyc > c) void'(wq.pop_back());
    while (dq.size() > 0 && dq[$] > c) void'(dq.pop_back());
    if (busy_hi > c) busy_hi = c;
  endfunction

  function automatic void accept(input int c);
    int lat;
    int d;
    lat     = L;
    done_rd = P - 1;
`ifdef COPY_FILL_EN
    if (fill_req) begin
      lat     = 0;
      done_rd = 0;
    end
`endif
    for (int a = 0; a < P; a++) begin
      d = int'(mem[a]);
`ifdef COPY_FILL_EN
      if (fill_req) d = int'(fill_col);
`endif
      wq.push_back('{cyc: c + 1 + lat + a, addr: a, data: d});
    end
    dq.push_back(c + P + lat + 1);
    busy_lo   = c + 1;
    busy_hi   = c + P + lat;
    idle_from = c + P + lat + 2;
  endfunction

  // drive one cycle of inputs and apply the reference rules to it
  task automatic step(input bit s, input bit a, input bit r);
    int c;
    c = cyc;
    bus.start = s;
    bus.abort = a;
    rst = r;
`ifdef COPY_FILL_EN
    bus.fill_en    = fill_req;
    bus.fill_color = fill_col;
`endif
    if (r) begin
      cut(c);
      if (idle_from > c + 1) idle_from = c + 1;
    end else if (s && c >= idle_from) begin
      accept(c);
    end else if (a && c >= busy_lo && c <= busy_hi) begin
      cut(c);
      idle_from = c + 1;
    end
    @(posedge clk);
    #1;
  endtask

  // start at offset 0; abort / reset / extra start at the given offsets (-1 = none)
  task automatic scenario(input int ab, input int rs, input int rp);
    for (int i = 0; i < P + L + 4; i++) begin
      step(i == 0 || i == rp, i == ab, i == rs);
      if (i == rs) begin
        chk("rst_busy", bus.busy, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_done", bus.done, 0);
      end
`ifdef COPY_FILL_EN
      if (fill_req) chk("fill_rd_addr", bus.rd_addr, 0);
`endif
    end
    for (int n = 0; n < 64 && (cyc < idle_from || bus.busy !== 1'b0); n++) step(0, 0, 0);
    chk("idle_timeout", bus.busy, 0);
  endtask

  always @(negedge clk) begin : mon
    wr_t  e;
    logic eb;
    if (mon_en) begin
      eb = (cyc >= busy_lo) && (cyc <= busy_hi);
      checks++;
      if (bus.busy !== eb) begin
        errors++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, bus.busy, eb);
      end
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL write_missing addr=%0d got=none exp_cyc=%0d", wq[0].addr, wq[0].cyc);
        void'(wq.pop_front());
      end
      if (bus.wr_en !== 1'b0) begin
        checks++;
        if (wq.size() == 0 || wq[0].cyc != cyc || bus.wr_en !== 1'b1) begin
          errors++;
          $display("FAIL write_unexpected cyc=%0d got addr=%0d data=%0h exp=no_write",
                   cyc, bus.wr_addr, bus.wr_data);
        end else begin
          e = wq.pop_front();
          if (int'(bus.wr_addr) != e.addr || int'(bus.wr_data) != e.data) begin
            errors++;
            $display("FAIL write_data cyc=%0d got addr=%0d data=%0h exp addr=%0d data=%0h",
                     cyc, bus.wr_addr, bus.wr_data, e.addr, e.data);
          end
        end
      end
      while (dq.size() > 0 && dq[0] < cyc) begin
        checks++;
        errors++;
        $display("FAIL done_missing got=none exp_cyc=%0d", dq[0]);
        void'(dq.pop_front());
      end
      if (bus.done !== 1'b0) begin
        checks++;
        if (dq.size() == 0 || dq[0] != cyc || bus.done !== 1'b1) begin
          errors++;
          $display("FAIL done_unexpected got_cyc=%0d exp=no_done", cyc);
        end else begin
          void'(dq.pop_front());
          checks++;
          if (int'(bus.rd_addr) != done_rd) begin
            errors++;
            $display("FAIL done_rd_addr got=%0d exp=%0d", bus.rd_addr, done_rd);
          end
        end
      end
    end
  end

  initial begin
    int ab;
    int rs;
    int rp;
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef COPY_FILL_EN
    bus.fill_en    = 1'b0;
    bus.fill_color = '0;
`endif
    for (int a = 0; a < P; a++) mem[a] = 8'(a) ^ 8'hA5;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    step(0, 0, 1);
    step(0, 0, 1);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_wr_en", bus.wr_en, 0);
    chk("reset_rd_addr", bus.rd_addr, 0);
    chk("reset_wr_addr", bus.wr_addr, 0);
    step(0, 0, 0);

    scenario(-1, -1, -1);
    chk("rd_addr_hold", bus.rd_addr, P - 1);
    scenario(-1, -1, 4);
    scenario(5, -1, -1);
    scenario(-1, -1, -1);
    scenario(-1, 6, -1);
    scenario(0, -1, -1);
    scenario(P + 1, -1, -1);
    scenario(-1, -1, P + L + 1);
    scenario(-1, -1, P + L + 2);

`ifdef COPY_FILL_EN
    fill_req = 1'b1;
    fill_col = 8'h1C;
    scenario(-1, -1, -1);
    fill_col = 8'($urandom);
    scenario(4, -1, -1);
    fill_req = 1'b0;
    scenario(-1, -1, -1);
`endif

    for (int it = 0; it < 40; it++) begin
      for (int a = 0; a < P; a++) mem[a] = 8'($urandom);
      ab = ($urandom_range(2) == 0) ? int'($urandom_range(P + L + 1, 1)) : -1;
      rs = ($urandom_range(5) == 0) ? int'($urandom_range(P + L + 1, 1)) : -1;
      rp = ($urandom_range(1) == 0) ? int'($urandom_range(P + L + 2, 1)) : -1;
`ifdef COPY_FILL_EN
      fill_req = ($urandom_range(3) == 0);
      fill_col = 8'($urandom);
`endif
      scenario(ab, rs, rp);
    end

    repeat (4) step(0, 0, 0);
    checks++;
    if (wq.size() != 0) begin
      errors++;
      $display("FAIL writes_left got=%0d exp=0", wq.size());
    end
    checks++;
    if (dq.size() != 0) begin
      errors++;
      $display("FAIL dones_left got=%0d exp=0", dq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
